// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared state encoding and frame constants for the SAD search sequencer
package sad_pkg;

   localparam int DEF_FRAME_W = 64;
   localparam int DEF_FRAME_H = 64;
   localparam int DEF_BLK     = 4;
   localparam int DEF_SAD_W   = 16;
   localparam int DEF_POS_W   = 6;

   localparam int COL_LAST = DEF_FRAME_W - DEF_BLK;
   localparam int ROW_LAST = DEF_FRAME_H - DEF_BLK;
   localparam logic [DEF_SAD_W-1:0] SAD_MAX = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      ADVANCE = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Highest top-left index a BLK-wide block can take inside a frame edge.
   function automatic int last_pos(input int frame, input int blk);
      return frame - blk;
   endfunction

endpackage

// File: rtl/sad_search_sequencer_if.sv
// rtl/sad_search_sequencer_if.sv - control, engine and result signals of the SAD search sequencer
interface sad_search_sequencer_if #(
   parameter int POS_W = 6,
   parameter int SAD_W = 16
);
   logic             Start;
   logic             Clear;
   logic             SadStart;
   logic [POS_W-1:0] SadRow;
   logic [POS_W-1:0] SadCol;
   logic             SadValid;
   logic [SAD_W-1:0] SadValue;
   logic             Busy;
   logic             Done;
   logic [SAD_W-1:0] MinSad;
   logic [POS_W-1:0] BestRow;
   logic [POS_W-1:0] BestCol;

   modport master (
      output Start, Clear, SadValid, SadValue,
      input  SadStart, SadRow, SadCol, Busy, Done, MinSad, BestRow, BestCol
   );

   modport slave (
      input  Start, Clear, SadValid, SadValue,
      output SadStart, SadRow, SadCol, Busy, Done, MinSad, BestRow, BestCol
   );
endinterface

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - keeps the smallest SAD seen and the position where it first occurred
module sad_min_tracker #(
   parameter int SAD_W = 16,
   parameter int POS_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [SAD_W-1:0] i_value,
   input  logic [POS_W-1:0] i_row,
   input  logic [POS_W-1:0] i_col,
   output logic [SAD_W-1:0] o_min,
   output logic [POS_W-1:0] o_row,
   output logic [POS_W-1:0] o_col
);

   logic [SAD_W-1:0] r_min;
   logic [POS_W-1:0] r_row;
   logic [POS_W-1:0] r_col;
   logic             w_better;

   // Strict compare so an equal later SAD never displaces the earlier position.
   assign w_better = i_valid && (i_value < r_min);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_min <= '1;
         r_row <= '0;
         r_col <= '0;
      end else if (i_clear) begin
         r_min <= '1;
         r_row <= '0;
         r_col <= '0;
      end else if (w_better) begin
         r_min <= i_value;
         r_row <= i_row;
         r_col <= i_col;
      end
   end

   assign o_min = r_min;
   assign o_row = r_row;
   assign o_col = r_col;

endmodule

// File: rtl/sad_search_sequencer.sv
// rtl/sad_search_sequencer.sv - walks the SAD engine over every block position and reports the minimum
module sad_search_sequencer
   import sad_pkg::*;
#(
   parameter int FRAME_W = DEF_FRAME_W,
   parameter int FRAME_H = DEF_FRAME_H,
   parameter int BLK     = DEF_BLK,
   parameter int SAD_W   = DEF_SAD_W,
   parameter int POS_W   = DEF_POS_W
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset_n,
   sad_search_sequencer_if.slave   bus
);

   localparam logic [POS_W-1:0] COL_END = POS_W'(last_pos(FRAME_W, BLK));
   localparam logic [POS_W-1:0] ROW_END = POS_W'(last_pos(FRAME_H, BLK));

   state_t           r_state;
   state_t           w_next;
   logic [POS_W-1:0] r_row;
   logic [POS_W-1:0] r_col;
   logic             w_last;
   logic             w_launch;
   logic             w_update;
   logic             w_clear_res;
   logic             w_sad_start;
   logic             w_busy;
   logic             w_done;
   logic [SAD_W-1:0] w_min;
   logic [POS_W-1:0] w_best_row;
   logic [POS_W-1:0] w_best_col;

   assign w_last      = (r_row == ROW_END) && (r_col == COL_END);
   assign w_launch    = (r_state == IDLE) && bus.Start && !bus.Clear;
   assign w_update    = (r_state == WAIT) && bus.SadValid && !bus.Clear;
   assign w_clear_res = bus.Clear || w_launch;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_sad_start = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_launch) w_next = ISSUE;
         end
         ISSUE: begin
            w_sad_start = 1'b1;
            w_busy      = 1'b1;
            w_next      = WAIT;
         end
         WAIT: begin
            w_busy = 1'b1;
            if (bus.SadValid) w_next = w_last ? DONE : ADVANCE;
         end
         ADVANCE: begin
            w_busy = 1'b1;
            w_next = ISSUE;
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // Clear aborts any search and never lets the pending result land.
      if (bus.Clear) w_next = IDLE;
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_clear_res) begin
         r_row <= '0;
         r_col <= '0;
      end else if (r_state == ADVANCE) begin
         if (r_col == COL_END) begin
            r_col <= '0;
            r_row <= r_row + POS_W'(1);
         end else begin
            r_col <= r_col + POS_W'(1);
         end
      end
   end

   sad_min_tracker #(
      .SAD_W (SAD_W),
      .POS_W (POS_W)
   ) u_min_tracker (
      .i_clk   (i_Clk),
      .i_rst_n (i_Reset_n),
      .i_clear (w_clear_res),
      .i_valid (w_update),
      .i_value (bus.SadValue),
      .i_row   (r_row),
      .i_col   (r_col),
      .o_min   (w_min),
      .o_row   (w_best_row),
      .o_col   (w_best_col)
   );

   assign bus.SadStart = w_sad_start;
   assign bus.SadRow   = r_row;
   assign bus.SadCol   = r_col;
   assign bus.Busy     = w_busy;
   assign bus.Done     = w_done;
   assign bus.MinSad   = w_min;
   assign bus.BestRow  = w_best_row;
   assign bus.BestCol  = w_best_col;

endmodule

// File: tb/tb_sad_search_sequencer.sv
// tb/tb_sad_search_sequencer.sv - directed vector bench for the SAD search sequencer on a 6x6 frame
module tb_sad_search_sequencer;

   localparam int FW   = 6;
   localparam int FH   = 6;
   localparam int BK   = 4;
   localparam int PW   = 6;
   localparam int SW   = 16;
   localparam int NCOL = FW - BK + 1;
   localparam int NPOS = (FH - BK + 1) * NCOL;
   localparam int NVEC = 6;

   typedef struct {
      string                     name;
      logic [NPOS-1:0][SW-1:0]   v;
      logic [SW-1:0]             min;
      int                        row;
      int                        col;
   } vec_t;

   logic clk     = 1'b0;
   bit   clk_en  = 1'b1;
   logic rst_n   = 1'b0;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[NVEC];
   logic [SW-1:0] tab[NPOS];
   int   issue_count = 0;
   int   cur_idx = 0;
   int   pend_cnt = 0;
   bit   pend = 0;
   bit   adv_next = 0;
   bit   inj_en = 0;

   sad_search_sequencer_if #(.POS_W(PW), .SAD_W(SW)) bus ();

   sad_search_sequencer #(
      .FRAME_W (FW),
      .FRAME_H (FH),
      .BLK     (BK),
      .SAD_W   (SW),
      .POS_W   (PW)
   ) dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .bus       (bus.slave)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Engine model: 3-cycle latency, optional spurious strobes in ISSUE and ADVANCE.
   always @(negedge clk) begin
      bus.SadValid = 1'b0;
      if (!rst_n) begin
         pend     = 0;
         adv_next = 0;
      end else begin
         if (adv_next) begin
            bus.SadValid = 1'b1;
            bus.SadValue = '0;
            adv_next     = 0;
         end
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               bus.SadValid = 1'b1;
               bus.SadValue = tab[cur_idx];
               pend         = 0;
               adv_next     = inj_en;
            end
         end
         if (bus.SadStart) begin
            check("issue_pos", {20'd0, bus.SadRow, bus.SadCol},
                  {20'd0, 6'(issue_count / NCOL), 6'(issue_count % NCOL)});
            cur_idx  = (issue_count < NPOS) ? issue_count : 0;
            issue_count++;
            pend     = 1;
            pend_cnt = 3;
            if (inj_en) begin
               bus.SadValid = 1'b1;
               bus.SadValue = '0;
            end
         end
      end
   end

   task automatic load(input int k);
      for (int i = 0; i < NPOS; i++) tab[i] = vecs[k].v[i];
   endtask

   task automatic run_search(input int k, input bit restart);
      bit done_seen = 0;
      bit busy_ok   = 1;
      load(k);
      issue_count = 0;
      @(negedge clk) bus.Start = 1'b1;
      @(negedge clk) bus.Start = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (bus.Done) begin
            done_seen = 1;
            break;
         end
         if (!bus.Busy) busy_ok = 0;
         bus.Start = restart && (cyc % 5 == 2);
         @(negedge clk);
      end
      bus.Start = 1'b0;
      check({vecs[k].name, " done_seen"}, {31'd0, done_seen}, 32'd1);
      check({vecs[k].name, " busy_during"}, {31'd0, busy_ok}, 32'd1);
      check({vecs[k].name, " busy_at_done"}, {31'd0, bus.Busy}, 32'd0);
      check({vecs[k].name, " issues"}, issue_count, NPOS);
      check({vecs[k].name, " min"}, {16'd0, bus.MinSad}, {16'd0, vecs[k].min});
      check({vecs[k].name, " row"}, {26'd0, bus.BestRow}, vecs[k].row);
      check({vecs[k].name, " col"}, {26'd0, bus.BestCol}, vecs[k].col);
      @(negedge clk);
      check({vecs[k].name, " done_once"}, {31'd0, bus.Done}, 32'd0);
      check({vecs[k].name, " min_hold"}, {16'd0, bus.MinSad}, {16'd0, vecs[k].min});
   endtask

   initial begin
      bit saw = 0;
      bus.Start    = 1'b0;
      bus.Clear    = 1'b0;
      bus.SadValid = 1'b0;
      bus.SadValue = '0;

      for (int i = 0; i < NPOS; i++) vecs[0].v[i] = 16'(100 - 10 * i);
      vecs[0].name = "ramp_down"; vecs[0].min = 16'd20; vecs[0].row = 2; vecs[0].col = 2;
      for (int i = 0; i < NPOS; i++) vecs[1].v[i] = 16'd50;
      vecs[1].v[4] = 16'd7; vecs[1].v[6] = 16'd7;
      vecs[1].name = "tie_first"; vecs[1].min = 16'd7; vecs[1].row = 1; vecs[1].col = 1;
      for (int i = 0; i < NPOS; i++) vecs[2].v[i] = 16'(10 + i);
      vecs[2].name = "ramp_up"; vecs[2].min = 16'd10; vecs[2].row = 0; vecs[2].col = 0;
      for (int i = 0; i < NPOS; i++) vecs[3].v[i] = 16'hFFFF;
      vecs[3].name = "all_max"; vecs[3].min = 16'hFFFF; vecs[3].row = 0; vecs[3].col = 0;
      for (int i = 0; i < NPOS; i++) vecs[4].v[i] = 16'd40;
      vecs[4].v[2] = 16'd1; vecs[4].v[5] = 16'd1;
      vecs[4].name = "col_edge"; vecs[4].min = 16'd1; vecs[4].row = 0; vecs[4].col = 2;
      for (int i = 0; i < NPOS; i++) vecs[5].v[i] = 16'd40;
      vecs[5].v[3] = 16'd0; vecs[5].v[8] = 16'd0;
      vecs[5].name = "row_wrap"; vecs[5].min = 16'd0; vecs[5].row = 1; vecs[5].col = 0;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.SadStart) saw = 1;
      end
      check("idle busy", {31'd0, bus.Busy}, 32'd0);
      check("idle done", {31'd0, bus.Done}, 32'd0);
      check("idle min", {16'd0, bus.MinSad}, 32'hFFFF);
      check("idle sadstart", {31'd0, saw}, 32'd0);

      for (int k = 0; k < NVEC; k++) run_search(k, 0);

      @(negedge clk) bus.Clear = 1'b1;
      @(negedge clk) bus.Clear = 1'b0;
      check("idle_clear min", {16'd0, bus.MinSad}, 32'hFFFF);
      check("idle_clear row", {26'd0, bus.BestRow}, 32'd0);

      run_search(0, 0);
      issue_count = 0;
      @(negedge clk) begin bus.Start = 1'b1; bus.Clear = 1'b1; end
      @(negedge clk) begin bus.Start = 1'b0; bus.Clear = 1'b0; end
      check("start_clear busy", {31'd0, bus.Busy}, 32'd0);
      check("start_clear min", {16'd0, bus.MinSad}, 32'hFFFF);
      repeat (5) @(negedge clk);
      check("start_clear issues", issue_count, 32'd0);

      // Abort while position 5 waits on the engine.
      load(0);
      issue_count = 0;
      saw = 0;
      @(negedge clk) bus.Start = 1'b1;
      @(negedge clk) bus.Start = 1'b0;
      for (int cyc = 0; cyc < 200 && issue_count < 6; cyc++) begin
         @(negedge clk);
         #1;
      end
      check("abort reached pos5", issue_count, 32'd6);
      @(negedge clk);
      check("abort pre min", {16'd0, bus.MinSad}, 32'd60);
      check("abort pre row", {26'd0, bus.BestRow}, 32'd1);
      bus.Clear = 1'b1;
      @(negedge clk) bus.Clear = 1'b0;
      check("abort busy", {31'd0, bus.Busy}, 32'd0);
      check("abort min", {16'd0, bus.MinSad}, 32'hFFFF);
      check("abort col", {26'd0, bus.BestCol}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.Done || bus.Busy) saw = 1;
      end
      check("abort no done", {31'd0, saw}, 32'd0);
      check("abort late valid", {16'd0, bus.MinSad}, 32'hFFFF);
      check("abort no reissue", issue_count, 32'd6);

      inj_en = 1;
      run_search(0, 1);
      inj_en = 0;
      repeat (2) @(negedge clk);

      // Asynchronous reset with the clock parked low.
      load(0);
      issue_count = 0;
      @(negedge clk) bus.Start = 1'b1;
      @(negedge clk) bus.Start = 1'b0;
      repeat (12) @(negedge clk);
      check("pre_reset busy", {31'd0, bus.Busy}, 32'd1);
      clk_en = 0;
      #2 rst_n = 1'b0;
      #1;
      check("async busy", {31'd0, bus.Busy}, 32'd0);
      check("async sadstart", {31'd0, bus.SadStart}, 32'd0);
      check("async pos", {20'd0, bus.SadRow, bus.SadCol}, 32'd0);
      check("async min", {16'd0, bus.MinSad}, 32'hFFFF);
      check("async best", {20'd0, bus.BestRow, bus.BestCol}, 32'd0);
      check("async done", {31'd0, bus.Done}, 32'd0);
      pend = 0;
      adv_next = 0;
      #2 rst_n = 1'b1;
      clk_en = 1;
      repeat (2) @(negedge clk);
      run_search(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
